// File: rtl/gpio_irq_top_if.sv
// Wishbone classic slave bus bundle for the GPIO/interrupt block.
// The slave modport is the register-file side, the master modport the bus host.
interface gpio_irq_top_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i,
    output wb_stb_i,
    output wb_we_i,
    output wb_adr_i,
    output wb_sel_i,
    output wb_dat_i,
    input  wb_dat_o,
    input  wb_ack_o
  );

  modport slave (
    input  wb_cyc_i,
    input  wb_stb_i,
    input  wb_we_i,
    input  wb_adr_i,
    input  wb_sel_i,
    input  wb_dat_i,
    output wb_dat_o,
    output wb_ack_o
  );
endinterface

// File: rtl/gpio_irq_top.sv
// GPIO block with per-pin direction, synchronized inputs and edge-triggered
// sticky interrupt status, behind a two-cycle Wishbone register interface.
module gpio_irq_top #(
  parameter int unsigned PORT_NUM    = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  gpio_irq_top_if.slave       wb,
  inout  tri   [PORT_NUM-1:0] gpio_pin,
  output logic                irq_o
);

  localparam logic [2:0] AddrOut    = 3'd0;
  localparam logic [2:0] AddrDir    = 3'd1;
  localparam logic [2:0] AddrIn     = 3'd2;
  localparam logic [2:0] AddrRiseEn = 3'd3;
  localparam logic [2:0] AddrFallEn = 3'd4;
  localparam logic [2:0] AddrStatus = 3'd5;

  logic [PORT_NUM-1:0] out_q, out_d;
  logic [PORT_NUM-1:0] dir_q, dir_d;
  logic [PORT_NUM-1:0] rise_en_q, rise_en_d;
  logic [PORT_NUM-1:0] fall_en_q, fall_en_d;
  logic [PORT_NUM-1:0] status_q, status_d;
  logic [PORT_NUM-1:0] sync_q [SYNC_STAGES];
  logic [PORT_NUM-1:0] prev_q;
  logic                started_q;
  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic                irq_q, irq_d;

  logic                access;
  logic                wr;
  logic [2:0]          reg_adr;
  logic [PORT_NUM-1:0] wmask;
  logic [PORT_NUM-1:0] wdata;
  logic [PORT_NUM-1:0] pin_in;
  logic [PORT_NUM-1:0] edge_set;
  logic [PORT_NUM-1:0] status_clr;
  logic [31:0]         rdata;

  // Only adr[4:2], the low PORT_NUM data bits and their byte lanes are decoded.
  logic unused_bus;
  assign unused_bus = ^{wb.wb_adr_i, wb.wb_dat_i, wb.wb_sel_i};

  assign access  = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr      = access & wb.wb_we_i;
  assign reg_adr = wb.wb_adr_i[4:2];
  assign wdata   = wb.wb_dat_i[PORT_NUM-1:0];

  always_comb begin
    wmask = '0;
    for (int k = 0; k < int'(PORT_NUM); k++) begin
      wmask[k] = wb.wb_sel_i[k/8];
    end
  end

  for (genvar k = 0; k < int'(PORT_NUM); k++) begin : g_pad
    assign gpio_pin[k] = dir_q[k] ? out_q[k] : 1'bz;
  end

  assign pin_in = sync_q[SYNC_STAGES-1];

  // Edges are ignored for the first cycle after reset so prev can settle.
  assign edge_set = started_q ?
      ((pin_in & ~prev_q & rise_en_q) | (~pin_in & prev_q & fall_en_q)) : '0;

  assign status_clr = (wr && reg_adr == AddrStatus) ? (wdata & wmask) : '0;

  always_comb begin
    rdata = '0;
    unique case (reg_adr)
      AddrOut:    rdata[PORT_NUM-1:0] = out_q;
      AddrDir:    rdata[PORT_NUM-1:0] = dir_q;
      AddrIn:     rdata[PORT_NUM-1:0] = pin_in;
      AddrRiseEn: rdata[PORT_NUM-1:0] = rise_en_q;
      AddrFallEn: rdata[PORT_NUM-1:0] = fall_en_q;
      AddrStatus: rdata[PORT_NUM-1:0] = status_q;
      default:    ;
    endcase
  end

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    if (wr) begin
      unique case (reg_adr)
        AddrOut:    out_d     = (out_q & ~wmask) | (wdata & wmask);
        AddrDir:    dir_d     = (dir_q & ~wmask) | (wdata & wmask);
        AddrRiseEn: rise_en_d = (rise_en_q & ~wmask) | (wdata & wmask);
        AddrFallEn: fall_en_d = (fall_en_q & ~wmask) | (wdata & wmask);
        default:    ;
      endcase
    end
    // Set is applied after clear so a same-cycle edge is never lost.
    status_d = (status_q & ~status_clr) | edge_set;
    ack_d    = access;
    dat_d    = access ? rdata : '0;
    irq_d    = |status_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      prev_q    <= '0;
      started_q <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      irq_q     <= 1'b0;
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      prev_q    <= pin_in;
      started_q <= 1'b1;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      irq_q     <= irq_d;
      sync_q[0] <= gpio_pin;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_gpio_irq_top.sv
// Randomized scoreboard bench for gpio_irq_top: a register/pad model predicts
// read data, pad levels and the interrupt; a bus monitor checks every ack.
module tb_gpio_irq_top;
  localparam int unsigned PN    = 24;
  localparam int unsigned SS    = 3;
  localparam logic [31:0] PMASK = 32'h00FF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;
  tri   [PN-1:0] gpio_pin;
  logic [PN-1:0] tb_drv = '0;
  logic [PN-1:0] tb_oe = '1;

  gpio_irq_top_if wb ();

  gpio_irq_top #(.PORT_NUM(PN), .SYNC_STAGES(SS)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .wb      (wb.slave),
    .gpio_pin(gpio_pin),
    .irq_o   (irq)
  );

  for (genvar k = 0; k < int'(PN); k++) begin : g_tbpad
    assign gpio_pin[k] = tb_oe[k] ? tb_drv[k] : 1'bz;
  end

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    logic [2:0]  adr;
  } exp_t;
  exp_t exp_q[$];

  // Reference register state
  logic [31:0] out_m, dir_m, rise_m, fall_m, status_m;

  function automatic logic [31:0] pad_m();
    logic [31:0] drv32;
    drv32 = 32'(tb_drv);
    return ((dir_m & out_m) | (~dir_m & drv32)) & PMASK;
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [31:0] rd_model(input logic [2:0] a);
    case (a)
      3'd0:    return out_m;
      3'd1:    return dir_m;
      3'd2:    return pad_m();
      3'd3:    return rise_m;
      3'd4:    return fall_m;
      3'd5:    return status_m;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every ack against the scoreboard; data must be 0 between acks.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb.wb_ack_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack with empty scoreboard at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.chk) check($sformatf("read_adr%0d", e.adr), wb.wb_dat_o, e.exp);
        end
      end else begin
        check("dat_idle", wb.wb_dat_o, 32'h0);
      end
    end
  end

  // Caller is always 1ns after a rising edge; returns likewise, after an idle cycle.
  task automatic bus(input bit we, input logic [2:0] a, input logic [3:0] sel,
                     input logic [31:0] dat, input bit chk);
    int n;
    exp_q.push_back('{chk, rd_model(a), a});
    wb.wb_adr_i = {$urandom_range(0, 32'h07FF_FFFF), a, 2'($urandom_range(0, 3))};
    wb.wb_we_i  = we;
    wb.wb_sel_i = sel;
    wb.wb_dat_i = dat;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!wb.wb_ack_o && n < 8);
    check("ack_latency", 32'(n), 32'd1);
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_irq();
    check("irq", 32'(irq), 32'(|status_m));
  endtask

  // Wait for a pad change to travel through the synchronizer, then log its edges.
  task automatic settle(input logic [31:0] old_pad);
    logic [31:0] new_pad;
    new_pad = pad_m();
    cycles(SS + 3);
    status_m |= ((~old_pad & new_pad & rise_m) | (old_pad & ~new_pad & fall_m)) & PMASK;
    check_irq();
  endtask

  task automatic drive_pads(input logic [PN-1:0] v);
    logic [31:0] old_pad;
    old_pad = pad_m();
    tb_drv  = v;
    if (pad_m() != old_pad) settle(old_pad);
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [3:0] sel, input logic [31:0] dat);
    logic [31:0] m, old_pad, new_dir, going_out;
    m = bmask(sel) & PMASK;
    if (a == 3'd1) begin
      // Hand pads over at the level OUT will drive so the pad never glitches.
      new_dir   = (dir_m & ~m) | (dat & m);
      going_out = new_dir & ~dir_m;
      drive_pads((tb_drv & ~going_out[PN-1:0]) | (out_m[PN-1:0] & going_out[PN-1:0]));
      tb_oe = ~(dir_m[PN-1:0] & new_dir[PN-1:0]);
    end
    old_pad = pad_m();
    bus(1'b1, a, sel, dat, 1'b0);
    case (a)
      3'd0: out_m    = (out_m & ~m) | (dat & m);
      3'd1: dir_m    = (dir_m & ~m) | (dat & m);
      3'd3: rise_m   = (rise_m & ~m) | (dat & m);
      3'd4: fall_m   = (fall_m & ~m) | (dat & m);
      3'd5: status_m = status_m & ~(dat & m);
      default: ;
    endcase
    tb_oe = ~dir_m[PN-1:0];
    if (pad_m() != old_pad) settle(old_pad);
    else check_irq();
  endtask

  task automatic read_reg(input logic [2:0] a);
    bus(1'b0, a, 4'($urandom_range(0, 15)), $urandom, 1'b1);
  endtask

  task automatic wait_edge_irq(input logic [PN-1:0] v, input string name);
    int n;
    tb_drv = v;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!irq && n < 20);
    check(name, 32'(n), 32'(SS + 2));
  endtask

  initial begin
    logic [2:0] a;
    bit         stayed;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    wb.wb_adr_i = '0;
    wb.wb_sel_i = '0;
    wb.wb_dat_i = '0;
    out_m = 0; dir_m = 0; rise_m = 0; fall_m = 0; status_m = 0;
    #23;
    check("reset_ack", 32'(wb.wb_ack_o), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_dat", wb.wb_dat_o, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycles(SS + 2);

    // Byte lanes from reset
    write_reg(3'd0, 4'h2, 32'hFFFF_FFFF);
    read_reg(3'd0);
    check("out_lane_model", out_m, 32'h0000_FF00);

    // Output drive
    write_reg(3'd1, 4'hF, 32'h0000_00FF);
    write_reg(3'd0, 4'hF, 32'h0000_00A5);
    check("pins_out", 32'(gpio_pin[7:0]), 32'hA5);
    read_reg(3'd0);
    read_reg(3'd2);

    // Rising edge on pin3, then ignored falling edge
    write_reg(3'd1, 4'hF, 32'h0);
    write_reg(3'd3, 4'hF, 32'h8);
    wait_edge_irq(tb_drv | PN'(8), "rise_irq_latency");
    cycles(2);
    status_m |= 32'h8;
    read_reg(3'd5);
    drive_pads(tb_drv & ~PN'(8));
    read_reg(3'd5);

    // Clear racing a new set: set must win
    tb_drv = tb_drv | PN'(8);
    cycles(SS);
    bus(1'b1, 3'd5, 4'hF, 32'h8, 1'b0);
    stayed = (irq == 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycles(1);
      if (irq != 1'b1) stayed = 1'b0;
    end
    check("race_irq_held", 32'(stayed), 32'h1);
    read_reg(3'd5);
    exp_q.push_back('{1'b0, 32'h0, 3'd5});
    wb.wb_adr_i = 32'h14; wb.wb_we_i = 1'b1; wb.wb_sel_i = 4'h1; wb.wb_dat_i = 32'h8;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    cycles(1);
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    status_m = 0;
    check("clr_irq_still_high", 32'(irq), 32'h1);
    cycles(1);
    check("clr_irq_fall", 32'(irq), 32'h0);
    cycles(1);
    read_reg(3'd5);

    // Masked upper bits, IN and reserved addresses
    write_reg(3'd1, 4'hF, 32'hFFFF_FFFF);
    read_reg(3'd1);
    write_reg(3'd6, 4'hF, 32'hFFFF_FFFF);
    read_reg(3'd6);
    write_reg(3'd7, 4'hF, 32'hFFFF_FFFF);
    read_reg(3'd7);
    write_reg(3'd2, 4'hF, 32'h1234_5678);
    read_reg(3'd2);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      a = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: write_reg(a, 4'($urandom_range(0, 15)), $urandom);
        5, 6:          drive_pads(PN'($urandom));
        default:       read_reg(a);
      endcase
    end
    for (int r = 0; r < 8; r++) read_reg(3'(r));

    // Make sure irq is high, then reset in the middle of an access
    write_reg(3'd1, 4'hF, 32'h0);
    write_reg(3'd3, 4'hF, 32'h1);
    drive_pads(tb_drv & ~PN'(1));
    drive_pads(tb_drv | PN'(1));
    check("pre_reset_irq", 32'(irq), 32'h1);
    wb.wb_adr_i = 32'h0; wb.wb_we_i = 1'b0; wb.wb_sel_i = 4'hF;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_ack", 32'(wb.wb_ack_o), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_dat", wb.wb_dat_o, 32'h0);
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    out_m = 0; dir_m = 0; rise_m = 0; fall_m = 0; status_m = 0;
    tb_oe = '1;
    cycles(2);
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycles(SS + 4);
    for (int r = 0; r < 8; r++) read_reg(3'(r));
    check_irq();

    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
        cycles(1);
        n++;
      end
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
